// File: rtl/fp8_pkg.sv
// Shared constants and types for the 8-bit float format {sign, exp[2:0], frac[3:0]}, bias 3.
package fp8_pkg;

  localparam int EXP_W   = 3;
  localparam int FRAC_W  = 4;
  localparam int BIAS    = 3;
  localparam int EXP_MAX = 7;

  // Quiet NaN produced for every invalid operation: sign 0, exp all ones, frac MSB set.
  localparam logic [7:0]        CANON_NAN = 8'h78;
  localparam logic [EXP_W-1:0]  INF_EXP   = 3'b111;
  localparam logic [FRAC_W-1:0] INF_FRAC  = 4'b0000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp8_t;

endpackage

// File: rtl/fp8_mult_if.sv
// Operand/result bundle between an fp8 multiplier and whatever feeds it.
interface fp8_mult_if;

  logic       in_valid;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       out_valid;
  logic [7:0] res;

  // Producer of operands, consumer of products.
  modport master (
    output in_valid, in_a, in_b,
    input  out_valid, res
  );

  // The multiplier itself.
  modport slave (
    input  in_valid, in_a, in_b,
    output out_valid, res
  );

endinterface

// File: rtl/fp8_round_norm.sv
// Normalizes a raw 10-bit significand product, denormalizes into the subnormal
// range when needed, rounds to nearest-even and applies overflow to infinity.
// The product is read as xx.xxxxxxxx: bit 8 is the hidden-bit position.
module fp8_round_norm
  import fp8_pkg::*;
(
  input  logic              sign,
  input  logic signed [5:0] exp_in,
  input  logic [9:0]        prod,
  output fp8_t              result
);

  logic [3:0]        lead_pos;
  logic [3:0]        lz;
  logic [9:0]        norm_m;
  logic signed [5:0] exp_n;
  logic signed [5:0] exp_s;
  logic [3:0]        shamt;
  logic [25:0]       wide;
  logic              hid;
  logic [3:0]        frac;
  logic              guard;
  logic              sticky;
  logic              inc;
  logic [5:0]        sum;
  logic signed [5:0] exp_r;
  logic [3:0]        frac_r;

  // Leading-one normalize, subnormal right shift with sticky, RNE round, overflow check.
  always_comb begin
    lead_pos = '0;
    for (int i = 0; i < 10; i++) begin
      if (prod[i]) lead_pos = 4'(i);
    end
    lz     = 4'd9 - lead_pos;
    norm_m = prod << lz;
    exp_n  = exp_in + $signed({2'b00, lead_pos}) - 6'sd8;

    if (exp_n < 6'sd1) begin
      shamt = 4'(6'sd1 - exp_n);
      exp_s = 6'sd1;
    end else begin
      shamt = 4'd0;
      exp_s = exp_n;
    end

    wide   = {norm_m, 16'h0000} >> shamt;
    hid    = wide[25];
    frac   = wide[24:21];
    guard  = wide[20];
    sticky = |wide[19:0];
    inc    = guard & (sticky | frac[0]);
    sum    = {1'b0, hid, frac} + {5'b00000, inc};

    if (sum[5]) begin
      exp_r  = exp_s + 6'sd1;
      frac_r = 4'b0000;
    end else if (sum[4]) begin
      exp_r  = exp_s;
      frac_r = sum[3:0];
    end else begin
      exp_r  = 6'sd0;
      frac_r = sum[3:0];
    end

    if (prod == 10'd0) begin
      result = '{sign: sign, exp: 3'b000, frac: 4'b0000};
    end else if (exp_r >= 6'sd7) begin
      result = '{sign: sign, exp: INF_EXP, frac: INF_FRAC};
    end else begin
      result = '{sign: sign, exp: exp_r[2:0], frac: frac_r};
    end
  end

endmodule

// File: rtl/fp8_mult_top.sv
// fp8 multiplier: unpacks operands, resolves NaN/inf/zero cases, multiplies
// significands and registers the rounded product with one cycle of latency.
module fp8_mult_top
  import fp8_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  fp8_mult_if.slave  bus
);

  fp8_t              a;
  fp8_t              b;
  logic              nan_a, nan_b;
  logic              inf_a, inf_b;
  logic              zero_a, zero_b;
  logic              prod_sign;
  logic [4:0]        sig_a, sig_b;
  logic signed [5:0] ea, eb;
  logic signed [5:0] exp_in;
  logic [9:0]        prod;
  fp8_t              rounded;
  fp8_t              next_res;

  assign a = fp8_t'(bus.in_a);
  assign b = fp8_t'(bus.in_b);

  // Operand classification, significand product and special-case selection.
  always_comb begin
    nan_a  = (a.exp == INF_EXP) && (a.frac != 4'b0000);
    nan_b  = (b.exp == INF_EXP) && (b.frac != 4'b0000);
    inf_a  = (a.exp == INF_EXP) && (a.frac == 4'b0000);
    inf_b  = (b.exp == INF_EXP) && (b.frac == 4'b0000);
    zero_a = (a.exp == 3'b000) && (a.frac == 4'b0000);
    zero_b = (b.exp == 3'b000) && (b.frac == 4'b0000);

    prod_sign = a.sign ^ b.sign;
    sig_a     = {a.exp != 3'b000, a.frac};
    sig_b     = {b.exp != 3'b000, b.frac};
    ea        = (a.exp == 3'b000) ? 6'sd1 : $signed({3'b000, a.exp});
    eb        = (b.exp == 3'b000) ? 6'sd1 : $signed({3'b000, b.exp});
    exp_in    = ea + eb - 6'sd3;
    prod      = {5'b00000, sig_a} * {5'b00000, sig_b};

    if (nan_a || nan_b) begin
      next_res = fp8_t'(CANON_NAN);
    end else if ((inf_a && zero_b) || (zero_a && inf_b)) begin
      next_res = fp8_t'(CANON_NAN);
    end else if (inf_a || inf_b) begin
      next_res = '{sign: prod_sign, exp: INF_EXP, frac: INF_FRAC};
    end else if (zero_a || zero_b) begin
      next_res = '{sign: prod_sign, exp: 3'b000, frac: 4'b0000};
    end else begin
      next_res = rounded;
    end
  end

  fp8_round_norm u_round_norm (
    .sign   (prod_sign),
    .exp_in (exp_in),
    .prod   (prod),
    .result (rounded)
  );

  // Output register: result only updates on valid operands, reset wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.res       <= 8'h00;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) bus.res <= next_res;
    end
  end

endmodule

// File: tb/tb_fp8_mult_top.sv
// Directed bench for fp8_mult_top with hand-computed expected products.
module tb_fp8_mult_top;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fp8_mult_if bus ();

  fp8_mult_top dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one operand pair and advance to just after the sampling edge.
  task automatic applyStimulus(input logic valid, input logic [7:0] op_a, input logic [7:0] op_b);
    bus.in_valid = valid;
    bus.in_a     = op_a;
    bus.in_b     = op_b;
    @(posedge clk);
    #1;
  endtask

  // Compare registered outputs against expected values.
  task automatic checkOutput(input string tag, input logic [7:0] exp_res, input logic exp_valid);
    checks++;
    assert (bus.res === exp_res) else begin
      errors++;
      $error("[TB] FAIL %s res: got %h expected %h", tag, bus.res, exp_res);
    end
    checks++;
    assert (bus.out_valid === exp_valid) else begin
      errors++;
      $error("[TB] FAIL %s out_valid: got %b expected %b", tag, bus.out_valid, exp_valid);
    end
  endtask

  // Directed sequence: reset, arithmetic vectors back to back, then control cases.
  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_a     = 8'h00;
    bus.in_b     = 8'h00;
    @(posedge clk);
    applyStimulus(1'b1, 8'h38, 8'h38);
    checkOutput("reset", 8'h00, 1'b0);
    rst = 1'b0;

    applyStimulus(1'b1, 8'h15, 8'h45); checkOutput("norm_15x45", 8'h2C, 1'b1);
    applyStimulus(1'b1, 8'h28, 8'h29); checkOutput("norm_28x29", 8'h23, 1'b1);
    applyStimulus(1'b1, 8'h38, 8'h29); checkOutput("norm_38x29", 8'h33, 1'b1);
    applyStimulus(1'b1, 8'h28, 8'h49); checkOutput("norm_28x49", 8'h43, 1'b1);
    applyStimulus(1'b1, 8'h38, 8'h28); checkOutput("exact_38x28", 8'h32, 1'b1);
    applyStimulus(1'b1, 8'h15, 8'h38); checkOutput("tie_15x38", 8'h20, 1'b1);
    applyStimulus(1'b1, 8'h08, 8'h49); checkOutput("sub_08x49", 8'h19, 1'b1);
    applyStimulus(1'b1, 8'h08, 8'h15); checkOutput("sub_08x15", 8'h03, 1'b1);
    applyStimulus(1'b1, 8'h28, 8'h08); checkOutput("sub_28x08", 8'h06, 1'b1);
    applyStimulus(1'b1, 8'h08, 8'h29); checkOutput("sub_08x29", 8'h06, 1'b1);
    applyStimulus(1'b1, 8'h08, 8'h08); checkOutput("underflow_08x08", 8'h01, 1'b1);
    applyStimulus(1'b1, 8'h01, 8'h01); checkOutput("underflow_zero", 8'h00, 1'b1);
    applyStimulus(1'b1, 8'h81, 8'h01); checkOutput("underflow_negzero", 8'h80, 1'b1);
    applyStimulus(1'b1, 8'h69, 8'h69); checkOutput("ovf_pos", 8'h70, 1'b1);
    applyStimulus(1'b1, 8'hE9, 8'h69); checkOutput("ovf_neg", 8'hF0, 1'b1);
    applyStimulus(1'b1, 8'h6F, 8'h38); checkOutput("ovf_round", 8'h70, 1'b1);
    applyStimulus(1'b1, 8'h70, 8'h00); checkOutput("inf_x_zero", 8'h78, 1'b1);
    applyStimulus(1'b1, 8'h80, 8'hF0); checkOutput("zero_x_inf", 8'h78, 1'b1);
    applyStimulus(1'b1, 8'h71, 8'h38); checkOutput("nan_a", 8'h78, 1'b1);
    applyStimulus(1'b1, 8'h70, 8'hFF); checkOutput("inf_x_nan", 8'h78, 1'b1);
    applyStimulus(1'b1, 8'hF0, 8'h38); checkOutput("inf_x_fin", 8'hF0, 1'b1);
    applyStimulus(1'b1, 8'hF0, 8'hF0); checkOutput("inf_x_inf", 8'h70, 1'b1);
    applyStimulus(1'b1, 8'h80, 8'h38); checkOutput("negzero", 8'h80, 1'b1);

    applyStimulus(1'b0, 8'h69, 8'h69); checkOutput("hold_1", 8'h80, 1'b0);
    applyStimulus(1'b0, 8'h38, 8'h28); checkOutput("hold_2", 8'h80, 1'b0);

    applyStimulus(1'b1, 8'h38, 8'h28); checkOutput("resume", 8'h32, 1'b1);
    rst = 1'b1;
    applyStimulus(1'b1, 8'h38, 8'h29); checkOutput("mid_reset", 8'h00, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b1, 8'h38, 8'h29); checkOutput("after_reset", 8'h33, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
